// File: rtl/smi_tx_pkg.sv
// smi_tx_pkg
// Shared definitions for the SMI TX deframer: FSM state type, output-word
// header constants, field offsets of the formatted FIFO word and a packing
// helper used both for decoded frames and for the quiet (abort-fill) word.
// Packing works in a 64-bit container; callers truncate to 2*SAMPLE_W+6.
package smi_tx_pkg;

  localparam int WORD_MAX = 64;

  localparam logic [1:0] HDR_I = 2'b10;
  localparam logic [1:0] HDR_Q = 2'b01;

  typedef enum logic {IDLE, COLLECT} state_t;

  // Output word, LSB first: pad(0) | Q | HDR_Q | tx_en | I | HDR_I
  localparam int unsigned OFF_Q_LSB = 1;

  function automatic int unsigned off_hdr_q_lsb(input int unsigned sw);
    return sw + 1;
  endfunction

  function automatic int unsigned off_tx_en(input int unsigned sw);
    return sw + 3;
  endfunction

  function automatic int unsigned off_i_lsb(input int unsigned sw);
    return sw + 4;
  endfunction

  function automatic int unsigned off_hdr_i_lsb(input int unsigned sw);
    return 2 * sw + 4;
  endfunction

  // Sample arguments must already be zero-extended from sw bits.
  function automatic logic [WORD_MAX-1:0] pack_word(input logic [31:0] i_smp,
                                                    input logic [31:0] q_smp,
                                                    input logic        tx_en,
                                                    input int unsigned sw);
    logic [WORD_MAX-1:0] w;
    w = '0;
    w = w | (64'(q_smp) << OFF_Q_LSB);
    w = w | (64'(HDR_Q) << off_hdr_q_lsb(sw));
    w = w | (64'(tx_en) << off_tx_en(sw));
    w = w | (64'(i_smp) << off_i_lsb(sw));
    w = w | (64'(HDR_I) << off_hdr_i_lsb(sw));
    return w;
  endfunction

  function automatic logic [WORD_MAX-1:0] quiet_word(input int unsigned sw);
    return pack_word(32'd0, 32'd0, 1'b0, sw);
  endfunction

endpackage

// File: rtl/smi_tx_deframer_swe_sync.sv
// smi_swe_sync
// Brings the asynchronous SMI write strobe and data bus into the clock
// domain. SWE is normalised to active-high, passed through a 2-FF
// synchroniser and one extra delay stage; the edge pulse marks the end of
// a strobe (1->0 of the normalised signal). Data goes through 3 FFs so the
// byte presented with o_edge was sampled while the strobe was still active.
// Ports:
//   i_clk   clock
//   i_rst   synchronous active-high reset
//   i_swe   raw SWE pin (polarity set by SWE_ACTIVE_HIGH)
//   i_data  raw SMI data bus
//   o_edge  one-cycle pulse per completed strobe
//   o_byte  byte aligned with o_edge
module smi_swe_sync #(
  parameter int BUS_W           = 8,
  parameter int SWE_ACTIVE_HIGH = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_swe,
  input  logic [BUS_W-1:0] i_data,
  output logic             o_edge,
  output logic [BUS_W-1:0] o_byte
);

  logic             w_swe_norm;
  logic             r_swe_s1;
  logic             r_swe_s2;
  logic             r_swe_d;
  logic [BUS_W-1:0] r_data_s1;
  logic [BUS_W-1:0] r_data_s2;
  logic [BUS_W-1:0] r_data_s3;

  assign w_swe_norm = (SWE_ACTIVE_HIGH != 0) ? i_swe : ~i_swe;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_swe_s1  <= 1'b0;
      r_swe_s2  <= 1'b0;
      r_swe_d   <= 1'b0;
      r_data_s1 <= '0;
      r_data_s2 <= '0;
      r_data_s3 <= '0;
    end else begin
      r_swe_s1  <= w_swe_norm;
      r_swe_s2  <= r_swe_s1;
      r_swe_d   <= r_swe_s2;
      r_data_s1 <= i_data;
      r_data_s2 <= r_data_s1;
      r_data_s3 <= r_data_s2;
    end
  end

  assign o_edge = r_swe_d & ~r_swe_s2;
  assign o_byte = r_data_s3;

endmodule

// File: rtl/smi_tx_deframer.sv
// smi_tx_deframer
// Collects SMI bytes, checks SOF (MSB=1) / continuation (MSB=0) framing,
// unpacks {chan, I, Q} from the concatenated payload bits and pushes one
// formatted word per good frame through a single-entry hold buffer.
//
// state   | meaning
// IDLE    | waiting for a byte with MSB=1 (byte 0)
// COLLECT | byte 0 seen, r_idx = next byte index (1..FRAME_BYTES-1)
//
// Ports:
//   i_sys_clk, i_rst              clock, synchronous active-high reset
//   i_smi_swe_srw, i_smi_data_in  async SMI strobe and data
//   i_mode                        0 strict, 1 push quiet word on abort
//   i_clr_cnt                     clear status counters
//   i_tx_fifo_full                FIFO backpressure
//   o_tx_fifo_push/_pushed_data/_chan  FIFO write side
//   o_smi_write_req               !i_tx_fifo_full
//   o_frame_cnt/o_err_cnt/o_ovf_cnt    saturating status counters
module smi_tx_deframer
  import smi_tx_pkg::*;
#(
  parameter int BUS_W           = 8,
  parameter int FRAME_BYTES     = 4,
  parameter int SAMPLE_W        = 13,
  parameter int CH_W            = 2,
  parameter int TIMEOUT_CYC     = 1024,
  parameter int SWE_ACTIVE_HIGH = 0,
  parameter int CNT_W           = 16
) (
  input  logic                    i_sys_clk,
  input  logic                    i_rst,
  input  logic                    i_smi_swe_srw,
  input  logic [BUS_W-1:0]        i_smi_data_in,
  input  logic                    i_mode,
  input  logic                    i_clr_cnt,
  input  logic                    i_tx_fifo_full,
  output logic                    o_tx_fifo_push,
  output logic [2*SAMPLE_W+5:0]   o_tx_fifo_pushed_data,
  output logic [CH_W-1:0]         o_tx_fifo_chan,
  output logic                    o_smi_write_req,
  output logic [CNT_W-1:0]        o_frame_cnt,
  output logic [CNT_W-1:0]        o_err_cnt,
  output logic [CNT_W-1:0]        o_ovf_cnt
);

  localparam int WORD_W = 2 * SAMPLE_W + 6;
  localparam int PL_W   = BUS_W - 1;
  localparam int ACC_W  = PL_W * FRAME_BYTES;
  localparam int IDX_W  = (FRAME_BYTES > 2) ? $clog2(FRAME_BYTES) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FRAME_BYTES - 1);
  localparam logic [WORD_W-1:0] QUIET    = WORD_W'(quiet_word(SAMPLE_W));

  logic               w_edge;
  logic [BUS_W-1:0]   w_byte;
  logic               w_sof;
  logic [ACC_W-1:0]   w_shifted;
  logic [CH_W-1:0]    w_chan;
  logic [SAMPLE_W-1:0] w_i;
  logic [SAMPLE_W-1:0] w_q;
  logic [WORD_W-1:0]  w_word;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [ACC_W-1:0]   r_acc, w_acc_nxt;
  logic [TMO_W-1:0]   r_tmo, w_tmo_nxt;
  logic               w_load;
  logic [WORD_W-1:0]  w_load_data;
  logic [CH_W-1:0]    w_load_chan;
  logic               w_frame_inc;
  logic               w_err_inc;
  logic               w_ovf_inc;
  logic               w_drain;

  logic               r_hold_vld;
  logic [WORD_W-1:0]  r_hold_data;
  logic [CH_W-1:0]    r_hold_chan;
  logic [CNT_W-1:0]   r_frame_cnt, r_err_cnt, r_ovf_cnt;

  smi_swe_sync #(
    .BUS_W           (BUS_W),
    .SWE_ACTIVE_HIGH (SWE_ACTIVE_HIGH)
  ) u_sync (
    .i_clk  (i_sys_clk),
    .i_rst  (i_rst),
    .i_swe  (i_smi_swe_srw),
    .i_data (i_smi_data_in),
    .o_edge (w_edge),
    .o_byte (w_byte)
  );

  // Byte 0 ends up most significant after FRAME_BYTES shifts; a new SOF
  // needs no clearing because stale bits are shifted out by then.
  assign w_sof     = w_byte[BUS_W-1];
  assign w_shifted = {r_acc[ACC_W-PL_W-1:0], w_byte[PL_W-1:0]};
  assign w_chan    = w_shifted[ACC_W-1 -: CH_W];
  assign w_i       = w_shifted[ACC_W-CH_W-1 -: SAMPLE_W];
  assign w_q       = w_shifted[ACC_W-CH_W-SAMPLE_W-1 -: SAMPLE_W];
  assign w_word    = WORD_W'(pack_word(32'(w_i), 32'(w_q), 1'b1, SAMPLE_W));

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_acc_nxt   = r_acc;
    w_tmo_nxt   = r_tmo;
    w_load      = 1'b0;
    w_load_data = '0;
    w_load_chan = '0;
    w_frame_inc = 1'b0;
    w_err_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        w_tmo_nxt = TMO_LOAD;
        if (w_edge) begin
          if (w_sof) begin
            w_acc_nxt   = w_shifted;
            w_idx_nxt   = IDX_W'(1);
            w_state_nxt = COLLECT;
          end else begin
            w_err_inc = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (w_edge) begin
          w_tmo_nxt = TMO_LOAD;
          w_acc_nxt = w_shifted;
          if (w_sof) begin
            w_err_inc   = 1'b1;
            w_load      = i_mode;
            w_load_data = QUIET;
            w_idx_nxt   = IDX_W'(1);
          end else if (r_idx == IDX_LAST) begin
            w_frame_inc = 1'b1;
            w_load      = 1'b1;
            w_load_data = w_word;
            w_load_chan = w_chan;
            w_idx_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end else if (r_tmo == '0) begin
          w_err_inc   = 1'b1;
          w_load      = i_mode;
          w_load_data = QUIET;
          w_idx_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_tmo_nxt = r_tmo - TMO_W'(1);
        end
      end
      default: begin
        w_idx_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_acc   <= '0;
      r_tmo   <= TMO_LOAD;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_acc   <= w_acc_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  // Hold buffer: a load while full and not draining is lost (overflow).
  assign w_drain   = r_hold_vld & ~i_tx_fifo_full;
  assign w_ovf_inc = w_load & r_hold_vld & ~w_drain;

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      r_hold_vld  <= 1'b0;
      r_hold_data <= '0;
      r_hold_chan <= '0;
    end else if (w_load && (!r_hold_vld || w_drain)) begin
      r_hold_vld  <= 1'b1;
      r_hold_data <= w_load_data;
      r_hold_chan <= w_load_chan;
    end else if (w_drain) begin
      r_hold_vld <= 1'b0;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst || i_clr_cnt) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
      r_ovf_cnt   <= '0;
    end else begin
      if (w_frame_inc && (r_frame_cnt != '1)) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      if (w_err_inc && (r_err_cnt != '1))     r_err_cnt   <= r_err_cnt + CNT_W'(1);
      if (w_ovf_inc && (r_ovf_cnt != '1))     r_ovf_cnt   <= r_ovf_cnt + CNT_W'(1);
    end
  end

  assign o_tx_fifo_push        = w_drain;
  assign o_tx_fifo_pushed_data = r_hold_data;
  assign o_tx_fifo_chan        = r_hold_chan;
  assign o_smi_write_req       = ~i_tx_fifo_full;
  assign o_frame_cnt           = r_frame_cnt;
  assign o_err_cnt             = r_err_cnt;
  assign o_ovf_cnt             = r_ovf_cnt;

endmodule

// File: tb/tb_smi_tx_deframer.sv
module tb_smi_tx_deframer;

  localparam int TMO = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        swe;
  logic [7:0]  din;
  logic        mode;
  logic        clr;
  logic        full;
  logic        push;
  logic [31:0] pdata;
  logic [1:0]  pchan;
  logic        wreq;
  logic [15:0] frame_cnt, err_cnt, ovf_cnt;

  smi_tx_deframer dut (
    .i_sys_clk             (clk),
    .i_rst                 (rst),
    .i_smi_swe_srw         (swe),
    .i_smi_data_in         (din),
    .i_mode                (mode),
    .i_clr_cnt             (clr),
    .i_tx_fifo_full        (full),
    .o_tx_fifo_push        (push),
    .o_tx_fifo_pushed_data (pdata),
    .o_tx_fifo_chan        (pchan),
    .o_smi_write_req       (wreq),
    .o_frame_cnt           (frame_cnt),
    .o_err_cnt             (err_cnt),
    .o_ovf_cnt             (ovf_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state, updated once per host byte.
  int          m_frame, m_err, m_ovf;
  bit          m_in_frame;
  bit          m_full;
  bit          m_hold_vld;
  logic [33:0] m_hold;
  logic [6:0]  m_pl[$];
  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];

  always @(negedge clk) if (push) got_q.push_back({pchan, pdata});

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  // Frame bits: payloads concatenated, byte 0 first; chan, I, Q from the top.
  function automatic logic [33:0] decode();
    logic [27:0] val;
    logic [1:0]  ch;
    logic [31:0] i_s, q_s, w;
    val = '0;
    foreach (m_pl[k]) val = (val << 7) | 28'(m_pl[k]);
    ch  = val[27:26];
    i_s = 32'(val[25:13]);
    q_s = 32'(val[12:0]);
    w = 32'h8000_0000 | (i_s << 17) | 32'h0001_0000 | 32'h0000_4000 | (q_s << 1);
    return {ch, w};
  endfunction

  function automatic void produce(input logic [33:0] w);
    if (m_full) begin
      if (m_hold_vld) m_ovf = sat(m_ovf);
      else begin
        m_hold_vld = 1'b1;
        m_hold     = w;
      end
    end else exp_q.push_back(w);
  endfunction

  function automatic void model_abort();
    m_err = sat(m_err);
    if (mode) produce({2'b00, 32'h8000_4000});
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (!m_in_frame) begin
      if (b[7]) begin
        m_pl.delete();
        m_pl.push_back(b[6:0]);
        m_in_frame = 1'b1;
      end else m_err = sat(m_err);
    end else if (b[7]) begin
      model_abort();
      m_pl.delete();
      m_pl.push_back(b[6:0]);
    end else begin
      m_pl.push_back(b[6:0]);
      if (m_pl.size() == 4) begin
        m_frame = sat(m_frame);
        produce(decode());
        m_in_frame = 1'b0;
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    din = b;
    swe = 1'b0;
    repeat (4) @(posedge clk);
    #1 swe = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    model_byte(b);
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  task automatic set_full(input logic v);
    @(posedge clk); #1;
    full   = v;
    m_full = v;
    if (!v && m_hold_vld) begin
      exp_q.push_back(m_hold);
      m_hold_vld = 1'b0;
    end
  endtask

  task automatic compare(input string tag);
    int n;
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(m_frame));
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'(m_err));
    check({tag, "_ovf_cnt"}, 64'(ovf_cnt), 64'(m_ovf));
    check({tag, "_push_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++)
      check($sformatf("%s_word%0d", tag, k), 64'(got_q[k]), 64'(exp_q[k]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_push", 64'(push), 64'd0);
    check("rst_data", 64'(pdata), 64'd0);
    check("rst_chan", 64'(pchan), 64'd0);
    rst = 1'b0;
    m_frame = 0; m_err = 0; m_ovf = 0;
    m_in_frame = 1'b0; m_hold_vld = 1'b0;
    m_pl.delete();
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; swe = 1'b1; din = 8'h00; mode = 1'b0; clr = 1'b0; full = 1'b0;
    m_full = 1'b0;
    repeat (3) @(posedge clk);
    do_reset();
    compare("reset");
    check("write_req_nf", 64'(wreq), 64'd1);

    // all-ones samples
    send_frame(8'h9F, 8'h7F, 8'h7F, 8'h7F);
    compare("basic");

    // stray continuation byte in IDLE
    send_byte(8'h12);
    send_frame(8'hC5, 8'h2A, 8'h55, 8'h01);
    compare("stray");

    // SOF mid-frame, strict then fill
    send_byte(8'h80); send_byte(8'h00);
    send_frame(8'h85, 8'h01, 8'h02, 8'h03);
    compare("resync_strict");
    mode = 1'b1;
    send_byte(8'h80); send_byte(8'h00);
    send_frame(8'h85, 8'h01, 8'h02, 8'h03);
    compare("resync_fill");

    // partial-frame timeout, fill then strict
    send_byte(8'h80);
    repeat (TMO - 40) @(posedge clk);
    #1 check("tmo_not_early", 64'(err_cnt), 64'(m_err));
    repeat (60) @(posedge clk);
    #1 model_abort(); m_in_frame = 1'b0;
    compare("timeout_fill");
    mode = 1'b0;
    send_byte(8'h80);
    repeat (TMO + 20) @(posedge clk);
    #1 model_abort(); m_in_frame = 1'b0;
    compare("timeout_strict");

    // backpressure and overflow
    set_full(1'b1);
    send_frame(8'hA1, 8'h11, 8'h22, 8'h33);
    send_frame(8'hB2, 8'h44, 8'h55, 8'h66);
    check("write_req_full", 64'(wreq), 64'd0);
    compare("ovf_held");
    set_full(1'b0);
    compare("ovf_release");

    // counter clear
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    m_frame = 0; m_err = 0; m_ovf = 0;
    compare("clear");

    // reset mid-frame
    send_byte(8'h85);
    do_reset();
    compare("rst_mid");
    send_frame(8'hE3, 8'h3C, 8'h5A, 8'h0F);
    compare("after_rst");

    // randomized traffic: good frames, stray bytes, truncated frames
    for (int it = 0; it < 30; it++) begin
      int kind;
      int trunc;
      mode = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 2);
      if (kind == 1) send_byte({1'b0, 7'($urandom_range(0, 127))});
      if (kind == 2) begin
        trunc = $urandom_range(1, 3);
        send_byte({1'b1, 7'($urandom_range(0, 127))});
        for (int k = 1; k < trunc; k++) send_byte({1'b0, 7'($urandom_range(0, 127))});
      end
      send_frame({1'b1, 7'($urandom_range(0, 127))}, {1'b0, 7'($urandom_range(0, 127))},
                 {1'b0, 7'($urandom_range(0, 127))}, {1'b0, 7'($urandom_range(0, 127))});
      compare($sformatf("rand%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
